// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage. Holds the PC, runs a single-outstanding-request
// handshake to instruction memory, and fills the IF/ID register through a
// one-entry skid buffer. The bench also runs it with PC_RESET set near the top
// of the address space so that PC wrap-around is exercised.
//  clk               rising-edge clock
//  reset_n           asynchronous active-low reset
//  imem_req          fetch request to instruction memory
//  imem_addr         fetch byte address, held stable while a request waits
//  imem_ready        memory completes the request; imem_rdata valid same cycle
//  imem_rdata        fetched instruction word
//  ID_stall          ID cannot accept; IF/ID holds
//  ID_B_taken        taken branch resolved in ID (one-cycle pulse)
//  ID_B_target       branch target byte address
//  IF_ID_instruction instruction presented to the decoder
//  IF_ID_pc          byte address of IF_ID_instruction
//  IF_ID_valid       IF_ID_instruction holds a real instruction
module instr_fetch_unit #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        ID_stall,
   input  logic        ID_B_taken,
   input  logic [31:0] ID_B_target,
   output logic [31:0] IF_ID_instruction,
   output logic [31:0] IF_ID_pc,
   output logic        IF_ID_valid
);
   typedef enum logic [1:0] {IDLE, FETCH, SQUASH} state_t;
   state_t      state, state_nx;
   logic [31:0] pc, pc_nx, sq_addr, skid_instr, skid_pc;
   logic        skid_valid, skid_valid_nx, accept, load, word_ok;
   // Request is a pure function of state, so an async reset drops it at once.
   assign imem_req  = state != IDLE;
   // A squashed request keeps its original address until memory completes it.
   assign imem_addr = state == SQUASH ? sq_addr : pc;
   assign accept    = imem_req & imem_ready;
   assign load      = ~IF_ID_valid | ~ID_stall;
   // Only a completed non-squashed request delivers a usable word.
   assign word_ok   = accept & (state == FETCH);
   always_comb begin
      skid_valid_nx = ID_B_taken ? 1'b0 : skid_valid ? ~load : word_ok & ~load;
      pc_nx         = ID_B_taken ? ID_B_target : word_ok ? pc + PC_STEP : pc;
      state_nx      = state;
      case (state)
         IDLE:    if (ID_B_taken || !skid_valid) state_nx = FETCH;
         FETCH:   if (ID_B_taken) state_nx = accept ? FETCH : SQUASH;
                  else if (accept && skid_valid_nx) state_nx = IDLE;
         SQUASH:  if (!ID_B_taken && accept) state_nx = FETCH;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         pc                <= PC_RESET;
         sq_addr           <= PC_RESET;
         skid_valid        <= 1'b0;
         skid_instr        <= '0;
         skid_pc           <= '0;
         IF_ID_instruction <= '0;
         IF_ID_pc          <= '0;
         IF_ID_valid       <= 1'b0;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         skid_valid <= skid_valid_nx;
         if (state != SQUASH) sq_addr <= pc;
         if (word_ok && !load) begin
            skid_instr <= imem_rdata;
            skid_pc    <= pc;
         end
         if (ID_B_taken) IF_ID_valid <= 1'b0;
         else if (load) begin
            IF_ID_valid       <= skid_valid | word_ok;
            IF_ID_instruction <= skid_valid ? skid_instr : word_ok ? imem_rdata : IF_ID_instruction;
            IF_ID_pc          <= skid_valid ? skid_pc : word_ok ? pc : IF_ID_pc;
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: two IF units (PC_RESET 0 and FFFF_FFF8) driven with the
// same directed and random stimulus, compared every cycle against a
// transaction-level model (PC plus a two-deep IF/ID+skid FIFO).
module tb_instr_fetch_unit;
   localparam logic [31:0] MAGIC = 32'hA5A5_0000;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic        imem_ready = 1'b0, ID_stall = 1'b0, ID_B_taken = 1'b0;
   logic [31:0] ID_B_target = '0;
   logic        req[2], val[2];
   logic [31:0] addr[2], rdata[2], ins[2], ipc[2];
   int          n_cmp = 0, n_err = 0;
   logic [31:0] m_pc[2], m_sq[2], m_qa[2][2];
   bit          m_busy[2], m_drop[2];
   int          m_cnt[2];
   always #5 clk = ~clk;
   assign rdata[0] = addr[0] ^ MAGIC;
   assign rdata[1] = addr[1] ^ MAGIC;
   instr_fetch_unit #(.PC_RESET(32'h0000_0000)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .imem_req(req[0]), .imem_addr(addr[0]),
      .imem_ready(imem_ready), .imem_rdata(rdata[0]), .ID_stall(ID_stall),
      .ID_B_taken(ID_B_taken), .ID_B_target(ID_B_target),
      .IF_ID_instruction(ins[0]), .IF_ID_pc(ipc[0]), .IF_ID_valid(val[0]));
   instr_fetch_unit #(.PC_RESET(32'hFFFF_FFF8)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .imem_req(req[1]), .imem_addr(addr[1]),
      .imem_ready(imem_ready), .imem_rdata(rdata[1]), .ID_stall(ID_stall),
      .ID_B_taken(ID_B_taken), .ID_B_target(ID_B_target),
      .IF_ID_instruction(ins[1]), .IF_ID_pc(ipc[1]), .IF_ID_valid(val[1]));
   function automatic logic [31:0] pr(input int k);
      return k == 0 ? 32'h0000_0000 : 32'hFFFF_FFF8;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = pr(k); m_sq[k] = pr(k);
         m_busy[k] = 0; m_drop[k] = 0; m_cnt[k] = 0;
      end
   endtask
   // One clock edge of the model: word queue = IF/ID head plus skid.
   task automatic m_edge(input int k, input bit rdy, input bit st, input bit tk, input logic [31:0] tgt);
      bit acc;
      int c0;
      logic [31:0] a;
      acc = m_busy[k] & rdy;
      c0  = m_cnt[k];
      a   = m_drop[k] ? m_sq[k] : m_pc[k];
      if (tk) begin
         m_cnt[k] = 0;
         if (!m_busy[k]) m_busy[k] = 1;
         else if (!m_drop[k] && !acc) begin m_drop[k] = 1; m_sq[k] = m_pc[k]; end
         m_pc[k] = tgt;
      end else begin
         if (c0 > 0 && !st) begin m_qa[k][0] = m_qa[k][1]; m_cnt[k]--; end
         if (acc && m_drop[k]) m_drop[k] = 0;
         else if (acc) begin
            m_qa[k][m_cnt[k]] = a;
            m_cnt[k]++;
            m_pc[k] += 32'd4;
            if (m_cnt[k] == 2) m_busy[k] = 0;
         end else if (!m_busy[k] && c0 < 2) m_busy[k] = 1;
      end
   endtask
   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("u%0d.imem_req", k), {31'd0, req[k]}, {31'd0, m_busy[k]});
         check($sformatf("u%0d.imem_addr", k), addr[k], m_drop[k] ? m_sq[k] : m_pc[k]);
         check($sformatf("u%0d.IF_ID_valid", k), {31'd0, val[k]}, {31'd0, m_cnt[k] > 0});
         if (m_cnt[k] > 0) begin
            check($sformatf("u%0d.IF_ID_pc", k), ipc[k], m_qa[k][0]);
            check($sformatf("u%0d.IF_ID_instruction", k), ins[k], m_qa[k][0] ^ MAGIC);
         end
      end
   endtask
   task automatic check_reset_values(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s.u%0d.imem_req", tag, k), {31'd0, req[k]}, 32'd0);
         check($sformatf("%s.u%0d.imem_addr", tag, k), addr[k], pr(k));
         check($sformatf("%s.u%0d.IF_ID_valid", tag, k), {31'd0, val[k]}, 32'd0);
         check($sformatf("%s.u%0d.IF_ID_pc", tag, k), ipc[k], 32'd0);
         check($sformatf("%s.u%0d.IF_ID_instruction", tag, k), ins[k], 32'd0);
      end
   endtask
   // Called at a falling edge: drive inputs, compare, advance the model across the rising edge.
   task automatic step(input bit rdy, input bit st, input bit tk, input logic [31:0] tgt);
      imem_ready = rdy; ID_stall = st; ID_B_taken = tk; ID_B_target = tgt;
      compare_all();
      @(posedge clk);
      for (int k = 0; k < 2; k++) m_edge(k, rdy, st, tk, tgt);
      @(negedge clk);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      m_reset();
      reset_n = 1'b1;
      repeat (5) step(1, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0);
      step(0, 0, 1, 32'h0000_0100);
      step(0, 0, 0, 0);
      repeat (4) step(1, 0, 0, 0);
      repeat (3) step(1, 1, 0, 0);
      step(1, 1, 1, 32'h0000_0200);
      repeat (4) step(1, 0, 0, 0);
      repeat (2) step(1, 1, 0, 0);
      repeat (4) step(1, 0, 0, 0);
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC));
      step(0, 0, 0, 0);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset_values("async_reset");
      m_reset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (6) step(1, 0, 0, 0);
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) == 0,
              $urandom() & 32'hFFFF_FFFC);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
